// File: rtl/usb_tx_pkg.sv
// Shared transmit-path definitions for the USB bit stuffer and NRZI encoder.
// TRAILING_STUFF_EN adds the StStuffLast state for a stuff bit after the last data bit.
package usb_tx_pkg;

    localparam int unsigned MAX_RUN_DEFAULT = 6;

    // Line-level framing bits agreed with the NRZI encoder
    localparam logic STUFF_BIT = 1'b0;
    localparam logic IDLE_BIT  = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
`ifdef TRAILING_STUFF_EN
        StStuff = 2'd2,
        StStuffLast = 2'd3
`else
        StStuff = 2'd2
`endif
    } stuff_state_t;

endpackage

// File: rtl/usb_bit_stuffer_fsm.sv
// Bit-stuffer control FSM: sequencing, registered pause and start/end framing strobes.
// TRAILING_STUFF_EN enables the trailing stuff bit after a packet ending on a full run.
module usb_bit_stuffer_fsm
    import usb_tx_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         end_i,
    input  logic         run_hit_i,
    output stuff_state_t state_o,
    output logic         pause_o,
    output logic         start_nrzi_o,
    output logic         end_nrzi_o
);

    stuff_state_t cs, ns;
    logic pause_d, pause_q;
    logic start_d, start_q;
    logic end_d, end_q;

    always_comb begin
        ns      = cs;
        start_d = 1'b0;
        end_d   = 1'b0;
        unique case (cs)
            StIdle, StSend: begin
                if ((cs == StSend) || start_i) begin
                    start_d = (cs == StIdle);
                    if (end_i) begin
`ifdef TRAILING_STUFF_EN
                        if (run_hit_i) begin
                            ns = StStuffLast;
                        end else begin
                            ns    = StIdle;
                            end_d = 1'b1;
                        end
`else
                        ns    = StIdle;
                        end_d = 1'b1;
`endif
                    end else begin
                        ns = run_hit_i ? StStuff : StSend;
                    end
                end
            end
            StStuff: ns = StSend;
`ifdef TRAILING_STUFF_EN
            StStuffLast: begin
                ns    = StIdle;
                end_d = 1'b1;
            end
`endif
            default: ns = StIdle;
        endcase
`ifdef TRAILING_STUFF_EN
        pause_d = (ns == StStuff) || (ns == StStuffLast);
`else
        pause_d = (ns == StStuff);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs      <= StIdle;
            pause_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            cs      <= ns;
            pause_q <= pause_d;
            start_q <= start_d;
            end_q   <= end_d;
        end
    end

    assign state_o      = cs;
    assign pause_o      = pause_q;
    assign start_nrzi_o = start_q;
    assign end_nrzi_o   = end_q;

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every MAX_RUN consecutive 1s.
// TRAILING_STUFF_EN also stuffs after a packet whose last bit completes a run.
module usb_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int unsigned MAX_RUN = MAX_RUN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic s_in,
    input  logic start_stuffer,
    input  logic end_stuffer,
    output logic pause,
    output logic s_out,
    output logic start_nrzi,
    output logic end_nrzi
);

    localparam int unsigned CW = $clog2(MAX_RUN + 1);
    localparam logic [CW-1:0] RunMax = CW'(MAX_RUN);

    stuff_state_t state;
    logic          accept, run_hit, in_stuff;
    logic [CW-1:0] run_base, run_inc;
    logic [CW-1:0] run_cnt_d, run_cnt_q;
    logic          s_out_d, s_out_q;

    always_comb begin
        accept   = (state == StSend) || ((state == StIdle) && start_stuffer);
`ifdef TRAILING_STUFF_EN
        in_stuff = (state == StStuff) || (state == StStuffLast);
`else
        in_stuff = (state == StStuff);
`endif
        // A new packet counts its first bit from zero
        run_base  = (state == StIdle) ? '0 : run_cnt_q;
        run_inc   = run_base + CW'(1);
        run_hit   = accept && s_in && (run_inc == RunMax);
        run_cnt_d = '0;
        s_out_d   = IDLE_BIT;
        if (accept) begin
            s_out_d   = s_in;
            run_cnt_d = s_in ? run_inc : '0;
        end else if (in_stuff) begin
            s_out_d = STUFF_BIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
            s_out_q   <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            s_out_q   <= s_out_d;
        end
    end

    usb_bit_stuffer_fsm fsm (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start_stuffer),
        .end_i       (end_stuffer),
        .run_hit_i   (run_hit),
        .state_o     (state),
        .pause_o     (pause),
        .start_nrzi_o(start_nrzi),
        .end_nrzi_o  (end_nrzi)
    );

    assign s_out = s_out_q;

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer; expected output cycles are queued from a bit-level model.
// Honours TRAILING_STUFF_EN in its model when the macro is defined.
module tb_usb_bit_stuffer;
    import usb_tx_pkg::*;

    localparam int unsigned MaxRun = 6;

    logic clk = 1'b0;
    logic rst, s_in, start_stuffer, end_stuffer;
    logic pause, s_out, start_nrzi, end_nrzi;

    // Each entry: {s_out, start_nrzi, end_nrzi, pause} for one output cycle
    logic [3:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    usb_bit_stuffer #(.MAX_RUN(MaxRun)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in         (s_in),
        .start_stuffer(start_stuffer),
        .end_stuffer  (end_stuffer),
        .pause        (pause),
        .s_out        (s_out),
        .start_nrzi   (start_nrzi),
        .end_nrzi     (end_nrzi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge: compare this cycle's outputs with the next queued entry (idle if none)
    task automatic check_cycle(input string tag);
        logic [3:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
        check(tag, {s_out, start_nrzi, end_nrzi, pause}, exp);
    endtask

    // Reference model; pat holds the packet MSB-first (first bit is pat[n-1])
    task automatic build_expected(input logic [31:0] pat, input int n);
        int   run;
        logic b, last, hit;
        run = 0;
        for (int i = 0; i < n; i++) begin
            b    = pat[n-1-i];
            last = (i == n - 1);
            run  = b ? run + 1 : 0;
            hit  = (run == MaxRun);
`ifdef TRAILING_STUFF_EN
            exp_q.push_back({b, i == 0, last && !hit, hit});
            if (hit) begin
                exp_q.push_back({1'b0, 1'b0, last, 1'b0});
                run = 0;
            end
`else
            exp_q.push_back({b, i == 0, last, hit && !last});
            if (hit && !last) begin
                exp_q.push_back(4'b0000);
                run = 0;
            end
`endif
        end
    endtask

    // Upstream model: a driven bit is consumed at the next edge only if pause is low this cycle
    task automatic send_packet(input string tag, input logic [31:0] pat, input int n);
        int   idx, guard;
        logic adv, started;
        idx     = 0;
        guard   = 0;
        started = 1'b0;
        build_expected(pat, n);
        while (idx < n && guard < 4 * n + 8) begin
            start_stuffer = !started;
            started       = 1'b1;
            s_in          = pat[n-1-idx];
            end_stuffer   = (idx == n - 1);
            adv           = !pause;
            @(negedge clk);
            check_cycle(tag);
            if (adv) idx++;
            guard++;
        end
        start_stuffer = 1'b0;
        s_in          = 1'b0;
        end_stuffer   = 1'b0;
        guard         = 0;
        while (exp_q.size() != 0 && guard < 8) begin
            @(negedge clk);
            check_cycle(tag);
            guard++;
        end
        tests++;
        assert (idx == n && exp_q.size() == 0) else begin
            fails++;
            $error("FAIL %s_done observed idx=%0d left=%0d expected idx=%0d left=0",
                   tag, idx, exp_q.size(), n);
        end
        exp_q.delete();
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            start_stuffer = 1'b0;
            s_in          = i[0];
            end_stuffer   = i[1];
            @(negedge clk);
            check_cycle(tag);
        end
        s_in        = 1'b0;
        end_stuffer = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        s_in          = 1'b0;
        start_stuffer = 1'b0;
        end_stuffer   = 1'b0;
        repeat (2) @(negedge clk);
        check_cycle("reset");
        check("reset_state", {1'b0, dut.run_cnt_q}, 4'b0000);
        check("reset_fsm", {2'b00, dut.fsm.cs}, {2'b00, StIdle});
        rst = 1'b0;

        idle_cycles("idle_noise", 6);

        send_packet("ones8", 32'b11111111, 8);
        idle_cycles("gap1", 1);
        send_packet("run5_0_run5", 32'b11111011111, 11);
        idle_cycles("gap2", 1);
        send_packet("end_on_run", 32'b00111111, 8);
        idle_cycles("gap3", 1);
        send_packet("ones13", 32'h1fff, 13);
        idle_cycles("gap4", 1);
        send_packet("single", 32'b1, 1);
        send_packet("b2b", 32'b0110, 4);
        idle_cycles("gap5", 1);

        // Reset after the fourth bit of 11111111
        for (int i = 0; i < 4; i++) begin
            start_stuffer = (i == 0);
            s_in          = 1'b1;
            end_stuffer   = 1'b0;
            @(negedge clk);
        end
        start_stuffer = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        check("rst_mid_out", {s_out, start_nrzi, end_nrzi, pause}, 4'b0000);
        check("rst_mid_fsm", {2'b00, dut.fsm.cs}, {2'b00, StIdle});
        check("rst_mid_cnt", {1'b0, dut.run_cnt_q}, 4'b0000);
        rst  = 1'b0;
        s_in = 1'b0;
        idle_cycles("post_rst", 1);
        send_packet("after_rst", 32'b10, 2);
        idle_cycles("tail", 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
